// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, datapath
// select values, RV32I opcodes and the immediate-format decode.
package multicycle_ctrl_pkg;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    // immediate extender formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operand A
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU decode class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // writeback / PC source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // RV32I opcodes handled by this controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Immediate format from the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        logic [1:0] fmt;
        fmt = IMM_I;
        case (opcode)
            OP_STORE:  fmt = IMM_S;
            OP_BRANCH: fmt = IMM_B;
            OP_JAL:    fmt = IMM_J;
            default:   fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_timer.sv
// Memory wait counter: counts stalled request cycles and flags a timeout
// on the stalled cycle that brings the count to MEM_TIMEOUT.
module mc_mem_timer
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_M1 = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // next count: clear on request entry or completion, else count stalls
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || ready_i) begin
            cnt_d = '0;
        end else if (req_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // a completing cycle never times out, so ready wins a coincident limit
    assign timeout_o = req_i && !ready_i && (cnt_q >= TIMEOUT_M1);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I subset control FSM. Outputs are decoded from the current
// state (Moore), except the branch PC write and the fetch-completion
// enables which also depend on zero / mem_ready.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic [3:0]  state_o
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic       set_illegal, set_bus_err;
    logic       req_state;
    logic       timer_clr;
    logic       timeout;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       instr_unused;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign instr_unused = ^{instr[31:15], instr[11:7]};

    // requesting states come straight from the state register so the
    // timer never sees a combinational path back through the FSM outputs
    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);
    assign timer_clr = (state_d != state_q) &&
                       ((state_d == S_FETCH) || (state_d == S_MEMREAD) ||
                        (state_d == S_MEMWRITE));

    mc_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (timer_clr),
        .req_i     (req_state),
        .ready_i   (mem_ready & req_state),
        .timeout_o (timeout)
    );

    assign imm_src = imm_src_of(opcode);

    // next-state and control decode
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        result_src  = RES_ALUOUT;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    state_d    = S_DECODE;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                case (funct3)
                    F3_BEQ: begin
                        pc_write = zero;
                        state_d  = S_FETCH;
                    end
                    F3_BNE: begin
                        pc_write = ~zero;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_TRAP;
                    end
                endcase
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal_d = illegal_q | set_illegal;
    assign bus_err_d = bus_err_q | set_bus_err;

    // state and sticky fault flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each stimulus cycle queues its
// hand-written expected outputs; a monitor pops and compares on the
// falling edge.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int TMO = 4;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_SW   = 32'h0050A623;
    localparam logic [31:0] I_JAL  = 32'h010000EF;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BLT  = 32'h0020C463;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ILL  = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = I_ADD;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic        illegal_instr, bus_error;
    logic [3:0]  state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       req, wr, adr, irw, pcw, rgw;
        logic [1:0] a, b, op, res, imm;
        logic       ill, be;
    } obs_t;

    typedef struct {
        obs_t o;
        int   id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state_o;   o.req = mem_req;   o.wr = mem_write; o.adr = adr_src;
        o.irw = ir_write; o.pcw = pc_write;  o.rgw = reg_write;
        o.a = alu_src_a;  o.b = alu_src_b;   o.op = alu_op;
        o.res = result_src; o.imm = imm_src; o.ill = illegal_instr; o.be = bus_error;
        return o;
    endfunction

    // en = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
    function automatic obs_t mk(input logic [3:0] st, input logic [5:0] en,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] op, input logic [1:0] res,
                                input logic [1:0] imm, input logic ill, input logic be);
        obs_t o;
        o.st = st;
        {o.req, o.wr, o.adr, o.irw, o.pcw, o.rgw} = en;
        o.a = a; o.b = b; o.op = op; o.res = res; o.imm = imm;
        o.ill = ill; o.be = be;
        return o;
    endfunction

    function automatic obs_t e_idle(input logic [1:0] imm);
        return mk(S_IDLE, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_fetch(input logic [1:0] imm, input logic rdy);
        if (rdy)
            return mk(S_FETCH, 6'b100110, 2'b00, 2'b10, 2'b00, 2'b10, imm, 1'b0, 1'b0);
        return mk(S_FETCH, 6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_dec(input logic [1:0] imm);
        return mk(S_DECODE, 6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_aluwb(input logic [1:0] imm);
        return mk(S_ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_memadr(input logic [1:0] imm);
        return mk(S_MEMADR, 6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, imm, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_memrd();
        return mk(S_MEMREAD, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_branch(input logic pcw);
        return mk(S_BRANCH, {4'b0000, pcw, 1'b0}, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
    endfunction

    function automatic obs_t e_trap(input logic [1:0] imm, input logic ill, input logic be);
        return mk(S_TRAP, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, imm, ill, be);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h (state %0d) required=%h (state %0d)",
                     name, act, act.st, exp, exp.st);
        end
    endtask

    // drive one cycle of inputs and queue what the outputs must be in it
    task automatic cyc(input logic [31:0] ins, input logic z, input logic rdy, input obs_t e);
        instr = ins;
        zero = z;
        mem_ready = rdy;
        step_id++;
        sb.push_back('{o: e, id: step_id});
        @(posedge clk);
        #1;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic rst_pulse(input string name, input logic [1:0] imm);
        #2;
        rst_n = 1'b0;
        #1;
        check(name, sample(), e_idle(imm));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // monitor: compare the queued expectation for each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("step%0d", e.id), sample(), e.o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), e_idle(2'b00));
        rst_n = 1'b1;

        // add: FETCH, DECODE, EXECR, ALUWB, FETCH
        cyc(I_ADD, 0, 1, e_idle(2'b00));
        cyc(I_ADD, 0, 1, e_fetch(2'b00, 1));
        cyc(I_ADD, 0, 1, e_dec(2'b00));
        cyc(I_ADD, 0, 1, mk(S_EXECR, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0));
        cyc(I_ADD, 0, 1, e_aluwb(2'b00));

        // lw with three stall cycles in MEMREAD
        cyc(I_LW, 0, 1, e_fetch(2'b00, 1));
        cyc(I_LW, 0, 1, e_dec(2'b00));
        cyc(I_LW, 0, 0, e_memadr(2'b00));
        repeat (3) cyc(I_LW, 0, 0, e_memrd());
        cyc(I_LW, 0, 1, e_memrd());
        cyc(I_LW, 0, 0, mk(S_MEMWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0));

        // sw
        cyc(I_SW, 0, 1, e_fetch(2'b01, 1));
        cyc(I_SW, 0, 1, e_dec(2'b01));
        cyc(I_SW, 0, 1, e_memadr(2'b01));
        cyc(I_SW, 0, 1, mk(S_MEMWRITE, 6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0));

        // jal
        cyc(I_JAL, 0, 1, e_fetch(2'b11, 1));
        cyc(I_JAL, 0, 1, e_dec(2'b11));
        cyc(I_JAL, 0, 1, mk(S_JAL, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 0, 0));
        cyc(I_JAL, 0, 1, e_aluwb(2'b11));

        // branches against both zero values
        cyc(I_BEQ, 1, 1, e_fetch(2'b10, 1));
        cyc(I_BEQ, 1, 1, e_dec(2'b10));
        cyc(I_BEQ, 1, 1, e_branch(1'b1));
        cyc(I_BNE, 1, 1, e_fetch(2'b10, 1));
        cyc(I_BNE, 1, 1, e_dec(2'b10));
        cyc(I_BNE, 1, 1, e_branch(1'b0));
        cyc(I_BEQ, 0, 1, e_fetch(2'b10, 1));
        cyc(I_BEQ, 0, 1, e_dec(2'b10));
        cyc(I_BEQ, 0, 1, e_branch(1'b0));
        cyc(I_BNE, 0, 1, e_fetch(2'b10, 1));
        cyc(I_BNE, 0, 1, e_dec(2'b10));
        cyc(I_BNE, 0, 1, e_branch(1'b1));

        // addi
        cyc(I_ADDI, 0, 1, e_fetch(2'b00, 1));
        cyc(I_ADDI, 0, 1, e_dec(2'b00));
        cyc(I_ADDI, 0, 1, mk(S_EXECI, 6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0));
        cyc(I_ADDI, 0, 1, e_aluwb(2'b00));

        // illegal opcode, then 20 cycles parked in TRAP with mem_ready high
        cyc(I_ILL, 0, 1, e_fetch(2'b00, 1));
        cyc(I_ILL, 0, 1, e_dec(2'b00));
        repeat (20) cyc(I_ILL, 0, 1, e_trap(2'b00, 1, 0));
        rst_pulse("rst_from_illegal", 2'b00);

        // branch with unsupported funct3
        cyc(I_BLT, 1, 1, e_idle(2'b10));
        cyc(I_BLT, 1, 1, e_fetch(2'b10, 1));
        cyc(I_BLT, 1, 1, e_dec(2'b10));
        cyc(I_BLT, 1, 1, e_branch(1'b0));
        repeat (2) cyc(I_BLT, 1, 1, e_trap(2'b10, 1, 0));
        rst_pulse("rst_from_blt", 2'b10);

        // fetch timeout: four stalled cycles then TRAP with bus_error
        cyc(I_ADD, 0, 0, e_idle(2'b00));
        repeat (TMO) cyc(I_ADD, 0, 0, e_fetch(2'b00, 0));
        repeat (3) cyc(I_ADD, 0, 1, e_trap(2'b00, 0, 1));
        rst_pulse("rst_from_bus_error", 2'b00);

        // ready arriving on the timeout cycle completes normally
        cyc(I_ADD, 0, 0, e_idle(2'b00));
        repeat (TMO - 1) cyc(I_ADD, 0, 0, e_fetch(2'b00, 0));
        cyc(I_ADD, 0, 1, e_fetch(2'b00, 1));
        cyc(I_ADD, 0, 0, e_dec(2'b00));
        cyc(I_ADD, 0, 0, mk(S_EXECR, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0));
        cyc(I_ADD, 0, 0, e_aluwb(2'b00));

        // load timeout in MEMREAD
        cyc(I_LW, 0, 1, e_fetch(2'b00, 1));
        cyc(I_LW, 0, 1, e_dec(2'b00));
        cyc(I_LW, 0, 0, e_memadr(2'b00));
        repeat (TMO) cyc(I_LW, 0, 0, e_memrd());
        repeat (2) cyc(I_LW, 0, 0, e_trap(2'b00, 0, 1));
        rst_pulse("rst_from_memread_timeout", 2'b00);

        // reset in the middle of an outstanding fetch, then restart
        cyc(I_ADD, 0, 0, e_idle(2'b00));
        repeat (2) cyc(I_ADD, 0, 0, e_fetch(2'b00, 0));
        rst_pulse("rst_mid_request", 2'b00);
        cyc(I_ADD, 0, 1, e_idle(2'b00));
        cyc(I_ADD, 0, 1, e_fetch(2'b00, 1));
        cyc(I_ADD, 0, 1, e_dec(2'b00));

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum wait cycles on an outstanding memory request before bus error (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 instr  in  32  current instruction from the IR; stable from the cycle after ir_write.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completes the current request this cycle.
REQ-007 mem_req  out  1  memory request valid.
REQ-008 mem_write  out  1  request is a store.
REQ-009 adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 ir_write, pc_write, reg_write  out  1 each  write enables.
REQ-011 alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-012 alu_src_b  out  2  ALU B select: 00 = rs2, 01 = extended immediate, 10 = constant 4.
REQ-013 alu_op  out  2  ALU decode class: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-014 result_src  out  2  writeback/PC select: 00 = ALU result register, 01 = memory data, 10 = ALU output.
REQ-015 imm_src  out  2  immediate extender format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 illegal_instr, bus_error  out  1 each  sticky fault flags.
REQ-017 state_o  out  4  current state encoding, for debug.

Function
REQ-018 imm_src is decoded combinationally from instr[6:0] in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other opcode -> 00.
REQ-019 Moore outputs from state (except pc_write in BRANCH); every output not listed for a state is 0.
REQ-020 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-021 FETCH: mem_req=1, adr_src=0; hold until mem_ready; in the mem_ready cycle ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, result_src=10; next state DECODE.
REQ-022 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
REQ-023 DECODE transitions by opcode: lw/sw -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, other -> TRAP with illegal_instr set.
REQ-024 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; lw -> MEMREAD, sw -> MEMWRITE.
REQ-025 MEMREAD: mem_req=1, adr_src=1; wait for mem_ready, then -> MEMWB.
REQ-026 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-027 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; wait for mem_ready, then -> FETCH.
REQ-028 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; next state ALUWB.
REQ-029 EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; next state ALUWB.
REQ-030 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-031 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
REQ-032 BRANCH pc_write: funct3=000 -> zero; funct3=001 -> ~zero; next state FETCH.
REQ-033 BRANCH with any other funct3: no pc_write; -> TRAP with illegal_instr set.
REQ-034 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; next state ALUWB.
REQ-035 Wait counter (8 bit): clears on entry to FETCH/MEMREAD/MEMWRITE and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
REQ-036 Reaching MEM_TIMEOUT with mem_ready still 0: -> TRAP, bus_error set, no write enable that cycle.
REQ-037 mem_ready arriving in the same cycle as the timeout wins: normal transition, no bus_error.
REQ-038 TRAP: all control outputs 0; absorbing until reset; fault flags hold.
REQ-039 mem_ready outside a requesting state is ignored.

Reset
REQ-040 rst_n low: state=IDLE, wait counter=0, illegal_instr=0, bus_error=0, all control outputs 0, asynchronously, including mid-request.
REQ-041 First mem_req is asserted in the second rising edge after rst_n deasserts (IDLE, then FETCH).

Structure
REQ-042 Shared package: state enumeration (4-bit), imm_src, alu_src_a/b, result_src, alu_op encodings and RV32I opcode constants; the immediate extender uses the same imm_src constants.
REQ-043 One sub-module: mc_mem_timer (wait counter plus timeout compare); the FSM stays in multicycle_ctrl.

Verification
REQ-044 add x1,x2,x3 with mem_ready=1 always -> FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in ALUWB; back to FETCH on cycle 5.
REQ-045 lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles, adr_src=1, then MEMWB with result_src=01, imm_src=00.
REQ-046 beq with zero=1 -> pc_write=1 in BRANCH, imm_src=10; bne with zero=1 -> pc_write=0.
REQ-047 Opcode 0000000 -> TRAP after DECODE, illegal_instr=1, all enables 0 for 20 cycles.
REQ-048 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, bus_error=1; rst_n pulse clears to IDLE.
REQ-049 sw then jal -> mem_write=1 with imm_src=01; jal gives pc_write=1 and imm_src=11, then ALUWB.
